// File: rtl/conv_mem_arbiter.sv
// rtl/conv_mem_arbiter.sv - round-robin, burst-limited arbiter sharing one single-port memory between R0/R1 readers and R2 writer
module conv_mem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              req2,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata2,
  output logic [2:0]        gnt,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic [1:0]        rid,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  state_e      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic        rvalid_q;
  logic [1:0]  rid_q;

  logic [2:0]        req_vec;
  logic [1:0]        cand0, cand1, cand2, winner;
  logic              own_req;
  logic [ADDR_W-1:0] own_addr;

  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign req_vec = {req2, req1, req0};

  // Candidates in round-robin order starting at rr_ptr.
  assign cand0  = rr_ptr_q;
  assign cand1  = rr_next(cand0);
  assign cand2  = rr_next(cand1);
  assign winner = req_vec[cand0] ? cand0 : (req_vec[cand1] ? cand1 : cand2);

  always_comb begin
    own_req  = 1'b0;
    own_addr = '0;
    case (owner_q)
      2'd0:    begin own_req = req0; own_addr = addr0; end
      2'd1:    begin own_req = req1; own_addr = addr1; end
      default: begin own_req = req2; own_addr = addr2; end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    gnt        = 3'b000;
    busy       = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_vec) begin
          owner_d    = winner;
          beat_cnt_d = 4'd0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        gnt      = 3'b001 << owner_q;
        busy     = 1'b1;
        mem_addr = own_addr;
        if (owner_q == 2'd2) mem_wdata = wdata2;
        if (own_req) begin
          mem_rd = (owner_q != 2'd2);
          mem_wr = (owner_q == 2'd2);
        end
        // A dropped request ends the burst without a beat; otherwise the last beat does.
        if (!own_req || beat_cnt_q == LAST_BEAT) begin
          state_d  = IDLE;
          rr_ptr_d = rr_next(owner_q);
        end else begin
          beat_cnt_d = beat_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= 2'd0;
      rr_ptr_q   <= 2'd0;
      beat_cnt_q <= 4'd0;
      rvalid_q   <= 1'b0;
      rid_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      rvalid_q   <= mem_rd;
      if (mem_rd) rid_q <= owner_q;
    end
  end

  assign rvalid = rvalid_q;
  assign rid    = rid_q;
  assign rdata  = mem_rdata;

endmodule

// File: tb/tb_conv_mem_arbiter.sv
// tb/tb_conv_mem_arbiter.sv - randomized scoreboard bench for conv_mem_arbiter
module tb_conv_mem_arbiter;

  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int MB   = 4;
  localparam int NCYC = 3000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, req2 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0, addr2 = '0;
  logic [DW-1:0] wdata2 = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic [2:0]    gnt;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic [1:0]    rid;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd, mem_wr;

  conv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0),
    .req1(req1), .addr1(addr1),
    .req2(req2), .addr2(addr2), .wdata2(wdata2),
    .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .rid(rid), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] data;
  } rd_t;
  rd_t rdq[$];

  int            remaining [3];
  int            gap       [3];
  logic [AW-1:0] cur_addr  [3];
  logic          acc       [3];

  logic          env_rd = 1'b0, env_wr = 1'b0;
  logic [AW-1:0] env_addr = '0;
  logic [DW-1:0] env_wdata = '0;

  logic [2:0] prev_g = '0, prev_req = '0;
  int         rr = 0;
  int         cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int owner_of(input logic [2:0] g);
    return (g == 3'b001) ? 0 : (g == 3'b010) ? 1 : 2;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int o);
    return (o == 0) ? addr0 : (o == 1) ? addr1 : addr2;
  endfunction

  // Monitor / scoreboard: expected behaviour derived from arbitration rules.
  always @(negedge clk) begin
    logic [2:0] reqv, exp_g;
    logic       beat;
    int         o;
    rd_t        e;
    if (!rst) begin
      check("rst_gnt", 32'(gnt), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_mem_rd", 32'(mem_rd), 0);
      check("rst_mem_wr", 32'(mem_wr), 0);
      check("rst_rvalid", 32'(rvalid), 0);
      check("rst_rid", 32'(rid), 0);
      prev_g = '0; prev_req = '0; rr = 0; cnt = 0;
      rdq.delete();
      for (int n = 0; n < 3; n++) acc[n] = 1'b0;
      env_rd = 1'b0; env_wr = 1'b0;
    end else begin
      reqv = {req2, req1, req0};
      exp_g = '0;
      if (prev_g == 3'b000) begin
        for (int i = 2; i >= 0; i--)
          if (prev_req[(rr + i) % 3]) exp_g = 3'(1 << ((rr + i) % 3));
        cnt = 0;
      end else begin
        o = owner_of(prev_g);
        if (prev_req[o] && cnt < MB) exp_g = prev_g;
        else rr = (o + 1) % 3;
      end
      check("gnt", 32'(gnt), 32'(exp_g));
      check("busy", 32'(busy), 32'(exp_g != 0));
      check("strobe_excl", 32'(mem_rd & mem_wr), 0);
      check("gnt_onehot0", 32'($onehot0(gnt)), 1);
      check("strobe_no_gnt", 32'((mem_rd | mem_wr) && gnt == 3'b000), 0);

      check("rvalid", 32'(rvalid), 32'(rdq.size() > 0));
      if (rdq.size() > 0) begin
        e = rdq.pop_front();
        if (rvalid) begin
          check("rid", 32'(rid), 32'(e.id));
          check("rdata", 32'(rdata), 32'(e.data));
        end
      end

      beat = 1'b0;
      o = 0;
      if (exp_g != 0) begin
        o = owner_of(exp_g);
        beat = reqv[o];
      end
      check("mem_rd", 32'(mem_rd), 32'(beat && o != 2));
      check("mem_wr", 32'(mem_wr), 32'(beat && o == 2));
      if (beat) begin
        check("mem_addr", 32'(mem_addr), 32'(addr_of(o)));
        if (o == 2) begin
          check("mem_wdata", 32'(mem_wdata), 32'(wdata2));
          ref_mem[addr2] = wdata2;
        end else begin
          rdq.push_back('{id: 2'(o), data: ref_mem[addr_of(o)]});
        end
      end
      if (exp_g == 0) begin
        check("idle_addr", 32'(mem_addr), 0);
        check("idle_wdata", 32'(mem_wdata), 0);
      end
      if (beat) cnt++;
      for (int n = 0; n < 3; n++) acc[n] = beat && (o == n);
      env_rd = mem_rd; env_wr = mem_wr; env_addr = mem_addr; env_wdata = mem_wdata;
      prev_g = exp_g;
      prev_req = reqv;
    end
  end

  initial begin
    int next_rst;
    next_rst = 700;
    for (int i = 0; i < 256; i++) begin
      mem[i] = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    for (int n = 0; n < 3; n++) begin
      remaining[n] = 0; gap[n] = 0; cur_addr[n] = '0; acc[n] = 1'b0;
    end
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      if (env_wr) mem[env_addr] = env_wdata;
      mem_rdata = env_rd ? mem[env_addr] : DW'($urandom);
      for (int n = 0; n < 3; n++) begin
        if (acc[n]) begin
          remaining[n]--;
          cur_addr[n]++;
          if (n == 2) wdata2 = DW'($urandom);
        end
        // Opening phase keeps all three requesters saturated.
        if (cyc < 45) begin
          gap[n] = 0;
          if (remaining[n] < 4) remaining[n] = 8;
        end else if (gap[n] > 0) begin
          gap[n]--;
        end else if (remaining[n] == 0) begin
          if ($urandom_range(0, 3) == 0) begin
            remaining[n] = $urandom_range(1, 9);
            cur_addr[n] = AW'($urandom);
          end
        end else if ($urandom_range(0, 9) == 0) begin
          gap[n] = $urandom_range(1, 2);
        end
      end
      req0 = remaining[0] > 0 && gap[0] == 0;
      req1 = remaining[1] > 0 && gap[1] == 0;
      req2 = remaining[2] > 0 && gap[2] == 0;
      addr0 = cur_addr[0];
      addr1 = cur_addr[1];
      addr2 = cur_addr[2];

      if (cyc >= next_rst && gnt == 3'b010 && req1) begin
        next_rst = (next_rst < 1900) ? 1900 : NCYC + 1;
        #1 rst = 1'b0;
        #1;
        check("rst_now_gnt", 32'(gnt), 0);
        check("rst_now_mem_rd", 32'(mem_rd), 0);
        check("rst_now_mem_wr", 32'(mem_wr), 0);
        @(posedge clk);
        #2 rst = 1'b1;
      end
    end

    req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
    repeat (MB + 4) @(posedge clk);
    @(negedge clk);
    #1;
    check("drain_rdq", 32'(rdq.size()), 0);
    check("final_gnt", 32'(gnt), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
